// File: rtl/csr_defs.sv
// CSR indices, exception codes and field positions shared by the CSR file and its timer.
package csr_defs;

  localparam int unsigned CSR_NUM_W = 14;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ECODE_W   = 6;
  localparam int unsigned ESUB_W    = 9;
  localparam int unsigned HWINT_W   = 8;

  localparam logic [CSR_NUM_W-1:0] CSR_CRMD   = 14'h000;
  localparam logic [CSR_NUM_W-1:0] CSR_PRMD   = 14'h001;
  localparam logic [CSR_NUM_W-1:0] CSR_ECFG   = 14'h004;
  localparam logic [CSR_NUM_W-1:0] CSR_ESTAT  = 14'h005;
  localparam logic [CSR_NUM_W-1:0] CSR_ERA    = 14'h006;
  localparam logic [CSR_NUM_W-1:0] CSR_BADV   = 14'h007;
  localparam logic [CSR_NUM_W-1:0] CSR_EENTRY = 14'h00C;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE0  = 14'h030;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE1  = 14'h031;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE2  = 14'h032;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE3  = 14'h033;
  localparam logic [CSR_NUM_W-1:0] CSR_TID    = 14'h040;
  localparam logic [CSR_NUM_W-1:0] CSR_TCFG   = 14'h041;
  localparam logic [CSR_NUM_W-1:0] CSR_TVAL   = 14'h042;
  localparam logic [CSR_NUM_W-1:0] CSR_TICLR  = 14'h044;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_PIL  = 6'h01;
  localparam logic [ECODE_W-1:0] ECODE_PIS  = 6'h02;
  localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
  localparam logic [ECODE_W-1:0] ECODE_PME  = 6'h04;
  localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
  localparam logic [ECODE_W-1:0] ECODE_ADE  = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3F;

  localparam int unsigned TCFG_EN       = 0;
  localparam int unsigned TCFG_PERIODIC = 1;
  localparam int unsigned TICLR_CLR     = 0;
  localparam int unsigned EENTRY_VA_LO  = 6;

  // LIE bit 10 does not exist
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

  function automatic logic [DATA_W-1:0] mwrite(input logic [DATA_W-1:0] old_val,
                                               input logic [DATA_W-1:0] wdata,
                                               input logic [DATA_W-1:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

  // Address-related exceptions latch the faulting VA into BADV
  function automatic logic ecode_sets_badv(input logic [ECODE_W-1:0] ecode);
    return ecode inside {ECODE_ADE, ECODE_ALE, ECODE_TLBR, ECODE_PIL,
                         ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI};
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: owns TCFG/TVAL, reloads on configuration write, counts down and flags expiry.
module csr_timer
  import csr_defs::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we,
  input  logic [DATA_W-1:0]  tcfg_wval,
  output logic [DATA_W-1:0]  tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               expire_c
);

  logic [TIMER_W-1:0] reload_c;
  logic [TIMER_W-1:0] wr_load_c;

  assign reload_c  = TIMER_W'({tcfg[DATA_W-1:2], 2'b00});
  assign wr_load_c = TIMER_W'({tcfg_wval[DATA_W-1:2], 2'b00});

  // A configuration write pre-empts counting for that cycle
  assign expire_c = !tcfg_we && tcfg[TCFG_EN] && (tval == TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      tval <= '0;
    end else if (tcfg_we) begin
      tcfg <= tcfg_wval;
      if (tcfg_wval[TCFG_EN]) tval <= wr_load_c;
    end else if (tcfg[TCFG_EN] && (tval != '0)) begin
      if (tval == TIMER_W'(1)) tval <= tcfg[TCFG_PERIODIC] ? reload_c : '0;
      else                     tval <= tval - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Control/status register file: CSR map, exception/ertn state update, interrupt sampling.
// Timer CSRs (TID/TCFG/TVAL/TICLR) and the counter exist only when CSR_TIMER_EN is defined.
module csr_file
  import csr_defs::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0,
  parameter int unsigned TIMER_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CSR_NUM_W-1:0] csr_num,
  input  logic                 csr_we,
  input  logic [DATA_W-1:0]    csr_wmask,
  input  logic [DATA_W-1:0]    csr_wdata,
  input  logic                 wb_ex,
  input  logic [ECODE_W-1:0]   wb_ecode,
  input  logic [ESUB_W-1:0]    wb_esubcode,
  input  logic [DATA_W-1:0]    wb_pc,
  input  logic [DATA_W-1:0]    wb_vaddr,
  input  logic                 ertn_flush,
  input  logic [HWINT_W-1:0]   hw_int_in,
  input  logic                 ipi_int_in,
  output logic [DATA_W-1:0]    csr_rvalue,
  output logic [DATA_W-1:0]    ex_entry,
  output logic [DATA_W-1:0]    ertn_entry,
  output logic                 has_int,
  output logic [1:0]           crmd_plv
);

`ifdef CSR_TIMER_EN
  localparam bit TIMER_PRESENT = 1'b1;
`else
  localparam bit TIMER_PRESENT = 1'b0;
`endif

  logic                 crmd_ie, crmd_da, crmd_pg;
  logic [1:0]           prmd_pplv;
  logic                 prmd_pie;
  logic [12:0]          ecfg_lie;
  logic [1:0]           is_sw;
  logic [HWINT_W-1:0]   is_hw;
  logic                 is_ipi, is_timer;
  logic [ECODE_W-1:0]   estat_ecode;
  logic [ESUB_W-1:0]    estat_esubcode;
  logic [DATA_W-1:0]    era, badv, tid, tcfg;
  logic [DATA_W-1:EENTRY_VA_LO] eentry_va;
  logic [DATA_W-1:0]    save [4];
  logic [TIMER_W-1:0]   tval;
  logic [12:0]          estat_is;
  logic [DATA_W-1:0]    wr_val_c;
  logic                 we_c;

  assign estat_is   = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
  assign we_c       = csr_we && !wb_ex && !ertn_flush;
  assign wr_val_c   = mwrite(csr_rvalue, csr_wdata, csr_wmask);
  assign ex_entry   = {eentry_va, 6'b0};
  assign ertn_entry = era;
  assign has_int    = crmd_ie && |(ecfg_lie & estat_is);

  // Read mux: unmapped bits and indices return zero
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {27'b0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
      CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  csr_rvalue = save[csr_num[1:0]];
      CSR_TID:    csr_rvalue = TIMER_PRESENT ? tid : '0;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = DATA_W'(tval);
      default:    csr_rvalue = '0;
    endcase
  end

  // Architectural state; wb_ex beats ertn_flush beats csr_we
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv       <= '0;
      crmd_ie        <= 1'b0;
      crmd_da        <= 1'b1;
      crmd_pg        <= 1'b0;
      prmd_pplv      <= '0;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= '0;
      is_sw          <= '0;
      is_hw          <= '0;
      is_ipi         <= 1'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
      era            <= '0;
      badv           <= '0;
      eentry_va      <= '0;
      tid            <= TID_RESET;
      for (int i = 0; i < 4; i++) save[i] <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        prmd_pplv      <= crmd_plv;
        prmd_pie       <= crmd_ie;
        crmd_plv       <= '0;
        crmd_ie        <= 1'b0;
        era            <= wb_pc;
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
        if (ecode_sets_badv(wb_ecode)) badv <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (csr_we) begin
        case (csr_num)
          CSR_CRMD:   {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= wr_val_c[4:0];
          CSR_PRMD:   {prmd_pie, prmd_pplv} <= wr_val_c[2:0];
          CSR_ECFG:   ecfg_lie <= wr_val_c[12:0] & ECFG_LIE_MASK;
          CSR_ESTAT:  is_sw <= wr_val_c[1:0];
          CSR_ERA:    era <= wr_val_c;
          CSR_BADV:   badv <= wr_val_c;
          CSR_EENTRY: eentry_va <= wr_val_c[DATA_W-1:EENTRY_VA_LO];
          CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                      save[csr_num[1:0]] <= wr_val_c;
          CSR_TID:    if (TIMER_PRESENT) tid <= wr_val_c;
          default:    ;
        endcase
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic timer_expire_c;
  logic tcfg_we_c;
  logic ticlr_c;

  assign tcfg_we_c = we_c && (csr_num == CSR_TCFG);
  assign ticlr_c   = we_c && (csr_num == CSR_TICLR) && wr_val_c[TICLR_CLR];

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tcfg_we   (tcfg_we_c),
    .tcfg_wval (wr_val_c),
    .tcfg      (tcfg),
    .tval      (tval),
    .expire_c  (timer_expire_c)
  );

  // A fresh expiry outranks a simultaneous TICLR clear
  always_ff @(posedge clk) begin
    if (reset)               is_timer <= 1'b0;
    else if (timer_expire_c) is_timer <= 1'b1;
    else if (ticlr_c)        is_timer <= 1'b0;
  end
`else
  logic unused_we;
  assign unused_we = we_c;
  assign tcfg      = '0;
  assign tval      = '0;
  assign is_timer  = 1'b0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed vector table, timer sequences, randomized run vs model.
module tb_csr_file;

`ifdef CSR_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [13:0] I_CRMD = 14'h0,  I_PRMD = 14'h1,  I_ECFG = 14'h4, I_ESTAT = 14'h5;
  localparam logic [13:0] I_ERA = 14'h6,   I_BADV = 14'h7,  I_EENTRY = 14'hC;
  localparam logic [13:0] I_SAVE0 = 14'h30, I_SAVE1 = 14'h31;
  localparam logic [13:0] I_TID = 14'h40,  I_TCFG = 14'h41, I_TVAL = 14'h42, I_TICLR = 14'h44;
  localparam logic [13:0] I_BAD = 14'h99;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] csr_rvalue, ex_entry, ertn_entry;
  logic        has_int;
  logic [1:0]  crmd_plv;

  int n_tests = 0;
  int n_fail  = 0;

  csr_file dut (
    .clk(clk), .reset(reset), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .csr_rvalue(csr_rvalue), .ex_entry(ex_entry),
    .ertn_entry(ertn_entry), .has_int(has_int), .crmd_plv(crmd_plv)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: one 32-bit word per architectural CSR
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry;
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];

  function automatic logic [31:0] wmask_of(input logic [13:0] idx);
    case (idx)
      I_CRMD:   return 32'h1F;
      I_PRMD:   return 32'h7;
      I_ECFG:   return 32'h1BFF;
      I_ESTAT:  return 32'h3;
      I_ERA, I_BADV, 14'h30, 14'h31, 14'h32, 14'h33: return 32'hFFFF_FFFF;
      I_EENTRY: return 32'hFFFF_FFC0;
      I_TID, I_TCFG: return TIMER_EN ? 32'hFFFF_FFFF : 32'h0;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] idx);
    case (idx)
      I_CRMD: return m_crmd;   I_PRMD: return m_prmd;   I_ECFG: return m_ecfg;
      I_ESTAT: return m_estat; I_ERA: return m_era;     I_BADV: return m_badv;
      I_EENTRY: return m_eentry;
      14'h30, 14'h31, 14'h32, 14'h33: return m_save[idx - 14'h30];
      I_TID:  return TIMER_EN ? m_tid : 32'h0;
      I_TCFG: return TIMER_EN ? m_tcfg : 32'h0;
      I_TVAL: return TIMER_EN ? m_tval : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_put(input logic [13:0] idx, input logic [31:0] v);
    case (idx)
      I_CRMD: m_crmd = v;   I_PRMD: m_prmd = v;   I_ECFG: m_ecfg = v;
      I_ESTAT: m_estat = v; I_ERA: m_era = v;     I_BADV: m_badv = v;
      I_EENTRY: m_eentry = v;
      14'h30, 14'h31, 14'h32, 14'h33: m_save[idx - 14'h30] = v;
      I_TID: m_tid = v;     I_TCFG: m_tcfg = v;
      default: ;
    endcase
  endtask

  function automatic logic m_has_int();
    return m_crmd[2] && |(m_ecfg[12:0] & m_estat[12:0]);
  endfunction

  task automatic model_tick();
    logic [31:0] crmd0, prmd0, tcfg0, tval0, wm;
    logic we, expire, clr;
    if (reset) begin
      m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
      m_eentry = 0; m_tid = 0; m_tcfg = 0; m_tval = 0;
      for (int i = 0; i < 4; i++) m_save[i] = 0;
      return;
    end
    crmd0 = m_crmd; prmd0 = m_prmd; tcfg0 = m_tcfg; tval0 = m_tval;
    we = csr_we && !wb_ex && !ertn_flush;
    expire = 1'b0;
    if (wb_ex) begin
      m_prmd = {29'b0, crmd0[2:0]};
      m_crmd[2:0] = 3'b0;
      m_era = wb_pc;
      m_estat[30:16] = {wb_esubcode, wb_ecode};
      if (wb_ecode inside {6'h08, 6'h09, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07})
        m_badv = wb_vaddr;
    end else if (ertn_flush) begin
      m_crmd[2:0] = prmd0[2:0];
    end else if (we) begin
      wm = wmask_of(csr_num) & csr_wmask;
      m_put(csr_num, (m_read(csr_num) & ~wm) | (csr_wdata & wm));
    end
    clr = we && csr_num == I_TICLR && csr_wdata[0] && csr_wmask[0];
    if (TIMER_EN) begin
      if (we && csr_num == I_TCFG) begin
        if (m_tcfg[0]) m_tval = {m_tcfg[31:2], 2'b00};
      end else if (tcfg0[0] && tval0 != 0) begin
        if (tval0 == 1) begin
          expire = 1'b1;
          m_tval = tcfg0[1] ? {tcfg0[31:2], 2'b00} : 32'h0;
        end else m_tval = tval0 - 1;
      end
      if (expire) m_estat[11] = 1'b1;
      else if (clr) m_estat[11] = 1'b0;
    end
    m_estat[9:2] = hw_int_in;
    m_estat[12] = ipi_int_in;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_we = 0; wb_ex = 0; ertn_flush = 0; csr_wmask = 0; csr_wdata = 0;
    wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_vaddr = 0;
  endtask

  task automatic cyc(input logic [13:0] num, input logic we, input logic [31:0] wd, input logic [31:0] wm);
    idle_inputs();
    hw_int_in = 0; ipi_int_in = 0;
    csr_num = num; csr_we = we; csr_wdata = wd; csr_wmask = wm;
    tick();
    csr_we = 0;
  endtask

  task automatic rd(input logic [13:0] idx);
    csr_num = idx;
    #1;
  endtask

  typedef struct {
    logic [13:0] num;  logic we;  logic [31:0] wdata, wmask;
    logic ex;  logic [5:0] ecode;  logic [31:0] pc, vaddr;
    logic ertn;  logic [7:0] hw;
    logic [13:0] rd;  logic [31:0] exp_rd;  logic exp_int;  logic [1:0] exp_plv;
    logic [31:0] exp_ent;
  } vec_t;

  function automatic vec_t vr(logic [13:0] num, logic we, logic [31:0] wd, logic [31:0] wm,
                              logic ex, logic [5:0] ec, logic [31:0] pc, logic [31:0] va,
                              logic ertn, logic [7:0] hw, logic [13:0] rdi, logic [31:0] erd,
                              logic eint, logic [1:0] eplv, logic [31:0] eent);
    vec_t v;
    v.num = num; v.we = we; v.wdata = wd; v.wmask = wm; v.ex = ex; v.ecode = ec;
    v.pc = pc; v.vaddr = va; v.ertn = ertn; v.hw = hw; v.rd = rdi; v.exp_rd = erd;
    v.exp_int = eint; v.exp_plv = eplv; v.exp_ent = eent;
    return v;
  endfunction

  localparam int NV = 23;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] EE = 32'h1C00_8000;
  vec_t tbl [NV];

  logic [13:0] pool [17];

  initial begin
    tbl[0]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_CRMD, 32'h8, 0,0, 0);
    tbl[1]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_ESTAT, 32'h0, 0,0, 0);
    tbl[2]  = vr(I_EENTRY,1,EE,ONES,  0,0,0,0,                 0,0, I_EENTRY, EE, 0,0, EE);
    tbl[3]  = vr(I_CRMD,1,32'h7,32'h7,0,0,0,0,                 0,0, I_CRMD, 32'hF, 0,3, EE);
    tbl[4]  = vr(I_CRMD,0,0,0,        1,6'h09,32'h1C000100,32'h1003, 0,0, I_PRMD, 32'h7, 0,0, EE);
    tbl[5]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_CRMD, 32'h8, 0,0, EE);
    tbl[6]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_ERA, 32'h1C000100, 0,0, EE);
    tbl[7]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_BADV, 32'h1003, 0,0, EE);
    tbl[8]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,0, I_ESTAT, 32'h0009_0000, 0,0, EE);
    tbl[9]  = vr(I_CRMD,0,0,0,        0,0,0,0,                 1,0, I_CRMD, 32'hF, 0,3, EE);
    tbl[10] = vr(I_CRMD,0,0,0,        1,6'h0B,32'h1C000200,32'hDEAD, 0,0, I_BADV, 32'h1003, 0,0, EE);
    tbl[11] = vr(I_SAVE0,1,32'h1234,ONES, 1,6'h0B,32'h1C000300,0, 0,0, I_SAVE0, 32'h0, 0,0, EE);
    tbl[12] = vr(I_CRMD,1,32'hFF,32'h3, 0,0,0,0,               0,0, I_CRMD, 32'hB, 0,3, EE);
    tbl[13] = vr(I_BAD,1,ONES,ONES,   0,0,0,0,                 0,0, I_BAD, 32'h0, 0,3, EE);
    tbl[14] = vr(I_ECFG,1,32'h4,ONES, 0,0,0,0,                 0,0, I_ECFG, 32'h4, 0,3, EE);
    tbl[15] = vr(I_CRMD,1,32'h4,32'h4,0,0,0,0,                 0,0, I_CRMD, 32'hF, 0,3, EE);
    tbl[16] = vr(I_CRMD,0,0,0,        0,0,0,0,                 0,8'h01, I_ESTAT, 32'h000B_0004, 1,3, EE);
    tbl[17] = vr(I_ECFG,1,ONES,ONES,  0,0,0,0,                 0,0, I_ECFG, 32'h1BFF, 0,3, EE);
    tbl[18] = vr(I_ESTAT,1,ONES,ONES, 0,0,0,0,                 0,0, I_ESTAT, 32'h000B_0003, 1,3, EE);
    tbl[19] = vr(I_CRMD,1,32'h0,32'h4,0,0,0,0,                 0,0, I_CRMD, 32'hB, 0,3, EE);
    tbl[20] = vr(I_SAVE1,1,ONES,ONES, 0,0,0,0,                 1,0, I_SAVE1, 32'h0, 0,0, EE);
    tbl[21] = vr(I_SAVE1,1,32'hA5A5A5A5,32'hFFFF0000, 0,0,0,0, 0,0, I_SAVE1, 32'hA5A50000, 0,0, EE);
    tbl[22] = vr(I_EENTRY,1,ONES,32'hFF, 0,0,0,0,              0,0, I_EENTRY, 32'h1C0080C0, 0,0, 32'h1C0080C0);

    pool = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31, 14'h32,
             14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h99};

    idle_inputs();
    csr_num = 0; hw_int_in = 0; ipi_int_in = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("reset ex_entry", ex_entry, 0);
    check("reset ertn_entry", ertn_entry, 0);
    check("reset has_int", 32'(has_int), 0);
    check("reset plv", 32'(crmd_plv), 0);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      csr_num = tbl[i].num; csr_we = tbl[i].we; csr_wdata = tbl[i].wdata; csr_wmask = tbl[i].wmask;
      wb_ex = tbl[i].ex; wb_ecode = tbl[i].ecode; wb_esubcode = 0; wb_pc = tbl[i].pc;
      wb_vaddr = tbl[i].vaddr; ertn_flush = tbl[i].ertn; hw_int_in = tbl[i].hw; ipi_int_in = 0;
      tick();
      idle_inputs();
      rd(tbl[i].rd);
      check($sformatf("row%0d rvalue", i), csr_rvalue, tbl[i].exp_rd);
      check($sformatf("row%0d has_int", i), 32'(has_int), 32'(tbl[i].exp_int));
      check($sformatf("row%0d plv", i), 32'(crmd_plv), 32'(tbl[i].exp_plv));
      check($sformatf("row%0d ex_entry", i), ex_entry, tbl[i].exp_ent);
    end

    if (TIMER_EN) begin
      cyc(I_ESTAT, 1, 0, 32'h3);
      cyc(I_ECFG, 1, 32'h800, ONES);
      cyc(I_CRMD, 1, 32'h4, 32'h4);
      check("tmr pre has_int", 32'(has_int), 0);
      rd(I_TID);   check("tid reset", csr_rvalue, 0);
      cyc(I_TID, 1, 32'h12345678, ONES);
      check("tid write", csr_rvalue, 32'h12345678);
      cyc(I_TCFG, 1, 32'hB, ONES);
      check("tcfg", csr_rvalue, 32'hB);
      rd(I_TVAL);  check("tval load", csr_rvalue, 8);
      for (int k = 7; k >= 1; k--) begin
        cyc(I_TVAL, 0, 0, 0);
        check($sformatf("tval %0d", k), csr_rvalue, k);
        check($sformatf("no int at %0d", k), 32'(has_int), 0);
      end
      cyc(I_TVAL, 0, 0, 0);
      check("tval reload", csr_rvalue, 8);
      check("expiry has_int", 32'(has_int), 1);
      rd(I_ESTAT); check("expiry is11", 32'(csr_rvalue[11]), 1);
      cyc(I_CRMD, 1, 0, 32'h4);
      check("ie clear has_int", 32'(has_int), 0);
      cyc(I_TICLR, 1, 1, 1);
      check("ticlr reads 0", csr_rvalue, 0);
      rd(I_ESTAT); check("ticlr is11", 32'(csr_rvalue[11]), 0);
      repeat (5) cyc(I_TVAL, 0, 0, 0);
      check("tval before race", csr_rvalue, 1);
      cyc(I_TICLR, 1, 1, 1);
      rd(I_ESTAT); check("race expiry wins", 32'(csr_rvalue[11]), 1);
      rd(I_TVAL);  check("race reload", csr_rvalue, 8);
      cyc(I_TCFG, 1, 32'hA, 32'h1);
      repeat (3) cyc(I_TVAL, 0, 0, 0);
      check("frozen tval", csr_rvalue, 8);
      cyc(I_TICLR, 1, 1, 1);
      cyc(I_TCFG, 1, 32'h1, ONES);
      repeat (3) cyc(I_TVAL, 0, 0, 0);
      check("initval0 tval", csr_rvalue, 0);
      rd(I_ESTAT); check("initval0 no int", 32'(csr_rvalue[11]), 0);
      cyc(I_TCFG, 1, 32'h13, ONES);
      repeat (2) cyc(I_TVAL, 0, 0, 0);
      check("tval midcount", csr_rvalue, 14);
    end else begin
      cyc(I_TCFG, 1, 32'hB, ONES);
      check("no tcfg", csr_rvalue, 0);
      repeat (3) cyc(I_TVAL, 0, 0, 0);
      check("no tval", csr_rvalue, 0);
      cyc(I_TID, 1, 32'h55, ONES);
      check("no tid", csr_rvalue, 0);
      rd(I_ESTAT); check("no is11", 32'(csr_rvalue[11]), 0);
    end

    // Reset asserted mid-activity restores reset values
    reset = 1; cyc(I_CRMD, 1, 32'h3, 32'h3); reset = 0;
    check("rst crmd", csr_rvalue, 32'h8);
    rd(I_TVAL); check("rst tval", csr_rvalue, 0);
    rd(I_TCFG); check("rst tcfg", csr_rvalue, 0);
    rd(I_TID);  check("rst tid", csr_rvalue, 0);
    check("rst ex_entry", ex_entry, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      csr_num = pool[$urandom_range(0, 16)];
      csr_we = ($urandom_range(0, 1) == 1);
      csr_wdata = $urandom;
      if (csr_num == I_TCFG) csr_wdata = {$urandom_range(0, 5), 2'(($urandom_range(0, 3)))} ;
      csr_wmask = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ONES;
      wb_ex = ($urandom_range(0, 7) == 0);
      wb_ecode = 6'($urandom);
      if ($urandom_range(0, 1) == 1) wb_ecode = ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h3F;
      wb_esubcode = 9'($urandom);
      wb_pc = $urandom; wb_vaddr = $urandom;
      ertn_flush = ($urandom_range(0, 7) == 0);
      hw_int_in = 8'($urandom);
      ipi_int_in = ($urandom_range(0, 3) == 0);
      reset = (i == 1500);
      tick();
      reset = 0;
      check($sformatf("rnd%0d rvalue idx %h", i, csr_num), csr_rvalue, m_read(csr_num));
      check($sformatf("rnd%0d ex_entry", i), ex_entry, m_eentry);
      check($sformatf("rnd%0d ertn_entry", i), ertn_entry, m_era);
      check($sformatf("rnd%0d has_int", i), 32'(has_int), 32'(m_has_int()));
      check($sformatf("rnd%0d plv", i), 32'(crmd_plv), 32'(m_crmd[1:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
